// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_write_arbiter: round-robin register-file write port plus busy scoreboard
// Revision: 1.0
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [4:0]        req0_reg,
  input  logic [4:0]        req1_reg,
  input  logic [DATA_W-1:0] req0_value,
  input  logic [DATA_W-1:0] req1_value,
  output logic              rf_write_enable,
  output logic [4:0]        rf_write_register,
  output logic [DATA_W-1:0] rf_write_value,
  input  logic              issue_valid,
  input  logic [4:0]        issue_reg,
  input  logic [4:0]        chk_reg1,
  input  logic [4:0]        chk_reg2,
  output logic              hazard,
  output logic [NREG-1:0]   busy
);

  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [4:0]        wreg_q, wreg_d;
  logic [DATA_W-1:0] wval_q, wval_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              w_gnt0, w_gnt1;
  logic              w_hs;

  // On a tie the grant goes to the requester that did not win last time.
  assign w_gnt0 = req0_valid & (~req1_valid | last_grant_q);
  assign w_gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready = w_gnt0 & ~reset;
  assign req1_ready = w_gnt1 & ~reset;
  assign w_hs       = req0_ready | req1_ready;

  always_comb begin
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    wreg_d       = wreg_q;
    wval_d       = wval_q;
    if (w_hs) begin
      last_grant_d = req1_ready;
      wreg_d       = req1_ready ? req1_reg : req0_reg;
      wval_d       = req1_ready ? req1_value : req0_value;
      we_d         = (wreg_d != 5'd0);
    end
  end

  assign busy_d[0] = 1'b0;

  generate
    for (genvar i = 1; i < NREG; i++) begin : g_busy
      // Issue (set) wins over a same-edge writeback (clear).
      assign busy_d[i] = (issue_valid && (issue_reg == 5'(i))) ? 1'b1 :
                         (we_q && (wreg_q == 5'(i)))           ? 1'b0 :
                         busy_q[i];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      wreg_q       <= 5'd0;
      wval_q       <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      wreg_q       <= wreg_d;
      wval_q       <= wval_d;
      busy_q       <= busy_d;
    end
  end

  assign rf_write_enable   = we_q;
  assign rf_write_register = wreg_q;
  assign rf_write_value    = wval_q;
  assign busy              = busy_q;
  assign hazard            = busy_q[chk_reg1] | busy_q[chk_reg2];

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning write data width.
REQ-002 SHALL have parameter NREG, default 32, meaning register count; address width is 5 bits.
REQ-003 SHALL have port clk  input  1  meaning single clock, rising edge.
REQ-004 SHALL have port reset  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1  meaning write request from execute (0) and load (1) units.
REQ-006 SHALL have ports req0_ready, req1_ready  output  1  meaning request accepted this cycle.
REQ-007 SHALL have ports req0_reg, req1_reg  input  5  meaning destination register.
REQ-008 SHALL have ports req0_value, req1_value  input  DATA_W  meaning write data.
REQ-009 SHALL have port rf_write_enable  output  1  meaning register file write strobe.
REQ-010 SHALL have port rf_write_register  output  5  meaning register file write address.
REQ-011 SHALL have port rf_write_value  output  DATA_W  meaning register file write data.
REQ-012 SHALL have ports issue_valid  input  1 and issue_reg  input  5  meaning an instruction that will write issue_reg was issued.
REQ-013 SHALL have ports chk_reg1, chk_reg2  input  5  meaning source registers to hazard-check.
REQ-014 SHALL have port hazard  output  1  meaning busy[chk_reg1] OR busy[chk_reg2], combinational.
REQ-015 SHALL have port busy  output  NREG  meaning pending-write scoreboard.

Function
REQ-016 SHALL arbitrate round-robin via a last_grant flop: both valid -> grant requester != last_grant; one valid -> grant it.
REQ-017 SHALL assert reqN_ready combinationally only for the granted requester, at most one per cycle; handshake = valid AND ready.
REQ-018 SHALL update last_grant to the granted index on every handshake; no handshake -> hold.
REQ-019 SHALL register the accepted request: on the edge ending a handshake cycle, rf_write_enable=1, rf_write_register/value = winner's reg/value; latency exactly 1 cycle.
REQ-020 SHALL drive rf_write_enable=0 the cycle after no handshake; rf_write_register/value SHALL hold their last values.
REQ-021 SHALL accept a request to register 0 (handshake completes, last_grant updates) but SHALL NOT assert rf_write_enable for it.
REQ-022 SHALL guarantee a continuously valid requester waits at most 1 cycle.
REQ-023 SHALL require requesters to hold reg/value stable while valid AND NOT ready; violation is undefined.
REQ-024 SHALL set busy[issue_reg] on the edge where issue_valid=1 and issue_reg != 0.
REQ-025 SHALL clear busy[rf_write_register] on each edge where rf_write_enable=1.
REQ-026 SHALL give set priority when set and clear target the same register on the same edge (busy stays 1).
REQ-027 SHALL keep busy[0]=0 always.
REQ-028 SHALL compute hazard from the current busy flops only (no bypass of same-cycle issue or clear).

Reset
REQ-029 SHALL on reset asynchronously force rf_write_enable=0, rf_write_register=0, rf_write_value=0, busy=0, last_grant=1 (requester 0 wins first tie).
REQ-030 SHALL hold reqN_ready=0 while reset is high; a request accepted before reset whose write has not yet appeared SHALL be discarded.
REQ-031 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-032 Tie after reset: req0 (reg 3, 0xAA) and req1 (reg 4, 0xBB) held valid -> cycle 0 req0_ready=1; next cycle rf_write 3/0xAA, req1_ready=1; following cycle rf_write 4/0xBB.
REQ-033 Sustained contention: both valid 6 cycles -> grants alternate 0,1,0,1,0,1; rf_write_enable=1 on 6 consecutive cycles.
REQ-034 Scoreboard: issue reg 7 -> busy[7]=1, hazard=1 with chk_reg1=7; req1 writes reg 7 -> busy[7]=0 the edge after rf_write_enable.
REQ-035 Same-edge set/clear: rf_write_enable=1 to reg 9 while issue_valid=1, issue_reg=9 -> busy[9] remains 1.
REQ-036 Register 0: req0 reg 0, value 0x55 -> req0_ready=1, rf_write_enable stays 0; issue reg 0 -> busy=0.
REQ-037 Mid-operation reset: assert reset between a handshake and the next edge -> rf_write_enable=0, busy=0 immediately; first tie after release goes to req0.
